// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types for the PC / fetch sequencer.
// Flag encodings match the address builder's instr_type->flag map.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FLAG_NONE   = 2'b00,
        FLAG_JAL    = 2'b01,
        FLAG_JALR   = 2'b10,
        FLAG_BRANCH = 2'b11
    } flag_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DELIVER = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_TRAP    = 3'd4
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/pc_fetch_sequencer_redirect_resolve.sv
// Decides whether a redirect is taken and produces its word-aligned target.
// MISALIGN_TRAP_EN adds the misalign flag and the raw (bit0-cleared) target.
module pc_fetch_sequencer_redirect_resolve
    import pc_fetch_sequencer_pkg::*;
(
    input  logic        valid_i,
    input  logic [1:0]  flag_i,
    input  logic [31:0] target_i,
    input  logic        cond_i,
    output logic        taken_o,
    output logic [31:0] target_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_o,
    output logic [31:0] raw_o
`endif
);

    flag_e       flag;
    logic [31:0] clean;

    // Taken decision; JALR drops bit 0 before anything looks at alignment
    always_comb begin
        flag    = flag_e'(flag_i);
        clean   = target_i;
        taken_o = 1'b0;
        unique case (flag)
            FLAG_JAL:    taken_o = valid_i;
            FLAG_JALR: begin
                taken_o = valid_i;
                clean   = {target_i[31:1], 1'b0};
            end
            FLAG_BRANCH: taken_o = valid_i & cond_i;
            default:     taken_o = 1'b0;
        endcase
        target_o = clean & ALIGN_MASK;
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_o = clean[1];
    assign raw_o      = clean;
`endif

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer.
// Define MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [1:0]  flag_branch_i,
    input  logic [31:0] pc_target_i,
    input  logic        branch_taken_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ack_i,
    input  logic [31:0] fetch_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        trap_o,
    output logic [31:0] trap_pc_o
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            out_q, out_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     ipc_q, ipc_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;

    logic            req;
    logic            ack;
    logic [31:0]     addr;
    logic            taken;
    logic            live;
    logic [31:0]     tgt;

`ifdef MISALIGN_TRAP_EN
    logic            misalign;
    logic [31:0]     raw_tgt;
    logic            trap_q, trap_d;
    logic [31:0]     tpc_q, tpc_d;
`endif

    pc_fetch_sequencer_redirect_resolve u_resolve (
        .valid_i    (redirect_valid_i),
        .flag_i     (flag_branch_i),
        .target_i   (pc_target_i),
        .cond_i     (branch_taken_i),
        .taken_o    (taken),
        .target_o   (tgt)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign),
        .raw_o      (raw_tgt)
`endif
    );

    // An issued request keeps its address until acked, whatever the PC does
    assign req  = out_q || (state_q == ST_FETCH && !stall_i);
    assign ack  = req && fetch_ack_i;
    assign addr = out_q ? addr_q : pc_q;
    assign live = (state_q == ST_FETCH) ||
                  (state_q == ST_DELIVER) ||
                  (state_q == ST_FLUSH);

    // Next-state, PC and request tracking; a taken redirect overrides all
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;
        cnt_nxt = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
`ifdef MISALIGN_TRAP_EN
        trap_d  = trap_q;
        tpc_d   = tpc_q;
`endif

        if (req && !fetch_ack_i) begin
            out_d  = 1'b1;
            addr_d = addr;
        end else if (ack) begin
            out_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (ack) begin
                    instr_d = fetch_data_i;
                    ipc_d   = addr;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (instr_ready_i && !stall_i) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == '0 && !out_d) begin
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP:    state_d = ST_TRAP;
            default:    state_d = ST_IDLE;
        endcase

        if (taken && live) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
                tpc_d   = raw_tgt;
            end else begin
                pc_d    = tgt;
                state_d = ST_FLUSH;
                cnt_d   = CW'(FLUSH_CYCLES);
            end
`else
            pc_d    = tgt;
            state_d = ST_FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES);
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            out_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Sticky trap record, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            tpc_q  <= '0;
        end else begin
            trap_q <= trap_d;
            tpc_q  <= tpc_d;
        end
    end

    assign trap_o    = trap_q;
    assign trap_pc_o = tpc_q;
`else
    assign trap_o    = 1'b0;
    assign trap_pc_o = '0;
`endif

    assign fetch_req_o   = req;
    assign fetch_addr_o  = addr;
    assign instr_valid_o = (state_q == ST_DELIVER);
    assign instr_o       = instr_q;
    assign pc_o          = ipc_q;
    assign flush_o       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer.
// Inputs change and outputs are checked on the falling edge.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [1:0]  flag_branch_i;
    logic [31:0] pc_target_i;
    logic        branch_taken_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_ack_i;
    logic [31:0] fetch_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        trap_o;
    logic [31:0] trap_pc_o;

    int total = 0;
    int bad   = 0;

    pc_fetch_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .flag_branch_i    (flag_branch_i),
        .pc_target_i      (pc_target_i),
        .branch_taken_i   (branch_taken_i),
        .fetch_req_o      (fetch_req_o),
        .fetch_addr_o     (fetch_addr_o),
        .fetch_ack_i      (fetch_ack_i),
        .fetch_data_i     (fetch_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .flush_o          (flush_o),
        .trap_o           (trap_o),
        .trap_pc_o        (trap_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ack, input logic [31:0] data,
                          input logic rdy, input logic rv,
                          input logic [1:0] flg, input logic [31:0] tgt,
                          input logic tk, input logic stl);
        fetch_ack_i      = ack;
        fetch_data_i     = data;
        instr_ready_i    = rdy;
        redirect_valid_i = rv;
        flag_branch_i    = flg;
        pc_target_i      = tgt;
        branch_taken_i   = tk;
        stall_i          = stl;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, fetch_req_o}, 0);
        chk({tag, "_addr"},  fetch_addr_o, 32'h0);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 0);
        chk({tag, "_instr"}, instr_o, 0);
        chk({tag, "_pc"},    pc_o, 0);
        chk({tag, "_flush"}, {31'd0, flush_o}, 0);
        chk({tag, "_trap"},  {31'd0, trap_o}, 0);
        chk({tag, "_tpc"},   trap_pc_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // FETCH: one cycle without ack, then the ack cycle; ends entering DELIVER
    task automatic fetch_pair(input string tag, input logic [31:0] a,
                              input logic [31:0] d);
        idle_cycle();
        chk({tag, "_req0"},  {31'd0, fetch_req_o}, 1);
        chk({tag, "_addr0"}, fetch_addr_o, a);
        chk({tag, "_nov"},   {31'd0, instr_valid_o}, 0);
        chk({tag, "_nofl"},  {31'd0, flush_o}, 0);
        @(negedge clk);
        set_in(1, d, 0, 0, 2'b00, 0, 0, 0);
        #1;
        chk({tag, "_req1"},  {31'd0, fetch_req_o}, 1);
        chk({tag, "_addr1"}, fetch_addr_o, a);
    endtask

    // DELIVER with ready=1 and an optional redirect presented alongside
    task automatic deliver(input string tag, input logic [31:0] a,
                           input logic [31:0] d, input logic rv,
                           input logic [1:0] flg, input logic [31:0] tgt,
                           input logic tk);
        @(negedge clk);
        set_in(0, 0, 1, rv, flg, tgt, tk, 0);
        #1;
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 1);
        chk({tag, "_instr"}, instr_o, d);
        chk({tag, "_pc"},    pc_o, a);
        chk({tag, "_noreq"}, {31'd0, fetch_req_o}, 0);
    endtask

    task automatic expect_flush(input string tag, input int n,
                                input logic reqv);
        for (int i = 0; i < n; i++) begin
            idle_cycle();
            chk({tag, "_flush"}, {31'd0, flush_o}, 1);
            chk({tag, "_fvalid"}, {31'd0, instr_valid_o}, 0);
            chk({tag, "_freq"}, {31'd0, fetch_req_o}, {31'd0, reqv});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        do_reset();

        // Sequential fetch 0x0..0xC with ack every second cycle
        for (int k = 0; k < 4; k++) begin
            fetch_pair("seq", 32'(4 * k), 32'hA000_0000 + 32'(k));
            deliver("seq", 32'(4 * k), 32'hA000_0000 + 32'(k),
                    0, 2'b00, 0, 0);
        end

        // JAL to 0x100 wins over the same-cycle handshake
        fetch_pair("jal", 32'h10, 32'hB000_0010);
        deliver("jal", 32'h10, 32'hB000_0010, 1, 2'b01, 32'h100, 0);
        expect_flush("jal", 2, 0);
        fetch_pair("jal_tgt", 32'h100, 32'hB000_0100);
        deliver("jal_tgt", 32'h100, 32'hB000_0100, 0, 2'b00, 0, 0);

        // Conditional branch: not taken, then taken to 0x40
        fetch_pair("bnt", 32'h104, 32'hC000_0104);
        deliver("bnt", 32'h104, 32'hC000_0104, 1, 2'b11, 32'h40, 0);
        fetch_pair("bt", 32'h108, 32'hC000_0108);
        deliver("bt", 32'h108, 32'hC000_0108, 1, 2'b11, 32'h40, 1);
        expect_flush("bt", 2, 0);
        fetch_pair("bt_tgt", 32'h40, 32'hC000_0040);
        deliver("bt_tgt", 32'h40, 32'hC000_0040, 0, 2'b00, 0, 0);

        // Redirect to 0x200 while the 0x44 request is outstanding
        @(negedge clk);
        set_in(0, 0, 0, 1, 2'b01, 32'h200, 0, 0);
        #1;
        chk("out_req", {31'd0, fetch_req_o}, 1);
        chk("out_addr", fetch_addr_o, 32'h44);
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            chk("out_hold_fl", {31'd0, flush_o}, 1);
            chk("out_hold_req", {31'd0, fetch_req_o}, 1);
            chk("out_hold_addr", fetch_addr_o, 32'h44);
        end
        @(negedge clk);
        set_in(1, 32'hDEAD_BEEF, 0, 0, 2'b00, 0, 0, 0);
        #1;
        chk("out_ack_fl", {31'd0, flush_o}, 1);
        chk("out_ack_addr", fetch_addr_o, 32'h44);
        fetch_pair("out_new", 32'h200, 32'hD000_0200);
        deliver("out_new", 32'h200, 32'hD000_0200, 0, 2'b00, 0, 0);

        // JALR to 0x103
        fetch_pair("jalr", 32'h204, 32'hE000_0204);
        deliver("jalr", 32'h204, 32'hE000_0204, 1, 2'b10, 32'h103, 0);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk("trap_o", {31'd0, trap_o}, 1);
            chk("trap_pc", trap_pc_o, 32'h102);
            chk("trap_noreq", {31'd0, fetch_req_o}, 0);
            chk("trap_nov", {31'd0, instr_valid_o}, 0);
        end
`else
        expect_flush("jalr", 2, 0);
        fetch_pair("jalr_tgt", 32'h100, 32'hE000_0100);
        chk("jalr_trap", {31'd0, trap_o}, 0);
        chk("jalr_tpc", trap_pc_o, 0);
        deliver("jalr_tgt", 32'h100, 32'hE000_0100, 0, 2'b00, 0, 0);
`endif
        do_reset();

        // Stalled FETCH still takes a redirect; then PC wrap
        @(negedge clk);
        set_in(0, 0, 0, 1, 2'b01, 32'hFFFF_FFFC, 0, 1);
        #1;
        chk("stall_noreq", {31'd0, fetch_req_o}, 0);
        expect_flush("wrap", 2, 0);
        fetch_pair("wrap", 32'hFFFF_FFFC, 32'hF000_FFFC);
        deliver("wrap", 32'hFFFF_FFFC, 32'hF000_FFFC, 0, 2'b00, 0, 0);
        idle_cycle();
        chk("wrap_req", {31'd0, fetch_req_o}, 1);
        chk("wrap_addr", fetch_addr_o, 32'h0);

        // Asynchronous reset with a request outstanding
        @(negedge clk);
        set_in(1, 32'h1234_5678, 0, 0, 2'b00, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        chk_reset("mid_hold");
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        fetch_pair("post", 32'h0, 32'h5555_0000);
        deliver("post", 32'h0, 32'h5555_0000, 0, 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
